adc_serial_sequencer: RTL and testbench
=======================================

# adc_serial_sequencer

Hardware sequencer for the ADS4128 ADC serial register interface (SEN/SCLK/SDATA/SDOUT/RESET) in the Husky capture FPGA, clocked from clk_usb. Software posts one command (register write, register read, or hardware-reset pulse) via a valid/ready handshake. The block then generates the complete 16-bit serial frame, or the reset pulse, at a programmable SCLK rate and returns read data with a one-cycle response strobe. This replaces per-edge software bit-banging with a single register write per transaction.

## Interface
Parameters:
- pDIV_WIDTH, 8, width of the SCLK half-period divider input
- pRESET_CYCLES, 4, clk_usb cycles ADC_RESET is held high on a hardware-reset command
- pRESET_WAIT, 16, clk_usb cycles of settle time after ADC_RESET falls, before the response

Ports:
- clk_usb  in  1  sole clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; command accepted on the cycle where cmd_valid && cmd_ready
- cmd_hwreset  in  1  command is a hardware-reset pulse; overrides cmd_read
- cmd_read  in  1  1 = register read, 0 = register write
- cmd_addr  in  8  ADC register address
- cmd_wdata  in  8  write data; ignored for reads
- clk_div  in  pDIV_WIDTH  SCLK half-period is H = clk_div+1 cycles; sampled at accept
- rsp_valid  out  1  one-cycle pulse when any command completes
- rsp_rdata  out  8  last read byte; held until the next read completes
- busy  out  1  equals ~cmd_ready
- ADC_SEN, ADC_SCLK, ADC_SDATA, ADC_RESET  out  1 each  ADC serial pins
- ADC_SDOUT  in  1  ADC serial readback

## Operation
- Reset (reset_n=0 at an edge) forces all of the following on the next cycle, from any state:
  - ADC_SEN=1, ADC_SCLK=1, ADC_SDATA=0, ADC_RESET=0
  - rsp_valid=0, rsp_rdata=0x00
  - state returns to IDLE with cmd_ready=1
- States: IDLE, SETUP, BIT_LO, BIT_HI, HOLD, GAP, RST_PULSE, RST_WAIT, DONE.
- On accept, latch the following:
  - frame = {cmd_addr, cmd_read ? 8'h00 : cmd_wdata}
  - clk_div and the command type
- Serial frame, MSB first, 16 bits:
  - SETUP: ADC_SEN=0, SCLK=1, SDATA=frame[15].
  - BIT_LO: SCLK=0. The ADC latches SDATA on this falling edge.
  - BIT_HI: SCLK=1, SDATA = next frame bit.
  - The sequence alternates BIT_LO/BIT_HI until 16 BIT_LO phases have completed, then goes to HOLD.
  - HOLD: SCLK=1, SEN=0.
  - GAP: SEN=1.
  - DONE: rsp_valid=1 for one cycle, then IDLE.
- Read capture:
  - Applies to bits 7..0, i.e. low phases 9..16.
  - ADC_SDOUT is shifted into a holding shift register (MSB first) on the last cycle of each BIT_LO.
  - rsp_rdata updates from that register on entry to DONE.
  - Write and hwreset commands never modify rsp_rdata.
- Register readout mode (the ADC's READOUT bit) is software's responsibility. The block does not insert it.
- Hardware reset command:
  - RST_PULSE: ADC_RESET=1 for pRESET_CYCLES cycles, SEN=1, SCLK=1.
  - RST_WAIT: ADC_RESET=0 for pRESET_WAIT cycles.
  - Then DONE.
- Changes to clk_div, cmd_* or cmd_valid while busy are ignored. No queueing.

## Timing
- Accept at edge 0.
- SETUP is visible in cycles 1..H. Each phase lasts exactly H cycles.
- Frame phase counts:
  - Phases: SETUP(1) + BIT_LO(16) + BIT_HI(15) + HOLD(1) + GAP(1) = 34 phases.
  - GAP ends at cycle 34H.
  - rsp_valid is high in cycle 34H+1; cmd_ready is 1 in the same cycle.
  - A new command can be accepted in that cycle, and its SETUP starts at cycle 34H+2.
- Hardware reset command: ADC_RESET is high in cycles 1..pRESET_CYCLES, and rsp_valid is in cycle pRESET_CYCLES+pRESET_WAIT+1.
- SDATA changes only on SCLK rising transitions (start of a high phase) or at SETUP entry. It is never changed at a falling edge.
- Sample point: the last cycle of BIT_LO, i.e. H-1 cycles after the falling edge. With clk_div=0 the sample is taken in the same cycle as the low phase.
- clk_div is a full pDIV_WIDTH-bit value; the maximum H is 2^pDIV_WIDTH with no wrap. The phase counter must be pDIV_WIDTH bits, counting 0..clk_div.
- If cmd_hwreset and cmd_read are both 1, a reset pulse is performed and no frame is sent.
- Reset asserted mid-frame:
  - SEN returns high the next cycle; no rsp_valid is issued.
  - rsp_rdata clears, and a partial read is discarded.

## Test plan
- Write, clk_div=0, addr 0x55, wdata 0xAA:
  - SEN low for cycles 1..33.
  - On the 16 falling edges, SDATA reads 0,1,0,1,0,1,0,1,1,0,1,0,1,0,1,0.
  - rsp_valid at cycle 35; rsp_rdata unchanged.
- Read, clk_div=0, addr 0x01, with an SDOUT model that drives 0xA5 on the falling edges of bits 7..0:
  - rsp_rdata=0xA5 at the rsp_valid cycle.
  - SDATA is 0 during the data bits.
- Read, clk_div=3 (H=4), SDOUT returning 0x3C:
  - Each SCLK level lasts 4 cycles.
  - rsp_valid at cycle 137; rsp_rdata=0x3C.
- hwreset, with cmd_read=1 also set:
  - ADC_RESET high in cycles 1..4, SEN stays 1 throughout.
  - rsp_valid at cycle 21; rsp_rdata unchanged.
- Back-to-back and held input:
  - cmd_valid is held high with changing cmd_addr during busy.
  - Only the values at accept are sent.
  - The second command is accepted in the rsp_valid cycle.
- Assert reset_n=0 for one cycle in the middle of a read:
  - All outputs return to their reset values next cycle.
  - No rsp_valid is issued; rsp_rdata=0x00; cmd_ready=1.

Source files
------------

// File: rtl/adc_serial_sequencer_if.sv
// Command/response handshake between the software register block and the
// ADS4128 serial sequencer.
interface adc_serial_sequencer_if #(
    parameter int pDIV_WIDTH = 8
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_hwreset;
    logic                  cmd_read;
    logic [7:0]            cmd_addr;
    logic [7:0]            cmd_wdata;
    logic [pDIV_WIDTH-1:0] clk_div;
    logic                  rsp_valid;
    logic [7:0]            rsp_rdata;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_hwreset, cmd_read, cmd_addr, cmd_wdata, clk_div,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_hwreset, cmd_read, cmd_addr, cmd_wdata, clk_div,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/adc_serial_sequencer.sv
// Generates one complete ADS4128 16-bit serial frame (write or read) or a
// hardware-reset pulse per accepted command, at a programmable SCLK rate.
module adc_serial_sequencer #(
    parameter int pDIV_WIDTH    = 8,
    parameter int pRESET_CYCLES = 4,
    parameter int pRESET_WAIT   = 16
) (
    input  logic                   clk_usb,
    input  logic                   reset_n,
    adc_serial_sequencer_if.slave  bus,
    output logic                   ADC_SEN,
    output logic                   ADC_SCLK,
    output logic                   ADC_SDATA,
    output logic                   ADC_RESET,
    input  logic                   ADC_SDOUT
);
    localparam int RST_MAX = (pRESET_CYCLES > pRESET_WAIT) ? pRESET_CYCLES : pRESET_WAIT;
    localparam int RST_CW  = (RST_MAX > 1) ? $clog2(RST_MAX) : 1;

    localparam logic [RST_CW-1:0]     RST_ONE        = RST_CW'(1);
    localparam logic [RST_CW-1:0]     RST_PULSE_LAST = RST_CW'(pRESET_CYCLES - 1);
    localparam logic [RST_CW-1:0]     RST_WAIT_LAST  = RST_CW'(pRESET_WAIT - 1);
    localparam logic [pDIV_WIDTH-1:0] PH_ONE         = pDIV_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SETUP     = 4'd1,
        S_BIT_LO    = 4'd2,
        S_BIT_HI    = 4'd3,
        S_HOLD      = 4'd4,
        S_GAP       = 4'd5,
        S_RST_PULSE = 4'd6,
        S_RST_WAIT  = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t                  state_r;
    logic [pDIV_WIDTH-1:0]   ph_cnt_r;
    logic [pDIV_WIDTH-1:0]   div_r;
    logic [3:0]              bit_cnt_r;
    logic [RST_CW-1:0]       rst_cnt_r;
    // Bits still to be shifted out after the MSB, which goes straight to SDATA at accept
    logic [14:0]             frame_r;
    logic [7:0]              rd_shift_r;
    logic                    is_read_r;
    logic                    cmd_ready_r;
    logic                    rsp_valid_r;
    logic [7:0]              rsp_rdata_r;
    logic                    sen_r;
    logic                    sclk_r;
    logic                    sdata_r;
    logic                    adc_reset_r;
    logic                    phase_end_s;

    assign phase_end_s = (ph_cnt_r == div_r);

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.busy      = ~cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign ADC_SEN       = sen_r;
    assign ADC_SCLK      = sclk_r;
    assign ADC_SDATA     = sdata_r;
    assign ADC_RESET     = adc_reset_r;

    // Sequencer FSM: state, phase timing, shift registers and all registered outputs
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            ph_cnt_r    <= '0;
            div_r       <= '0;
            bit_cnt_r   <= 4'd0;
            rst_cnt_r   <= '0;
            frame_r     <= 15'd0;
            rd_shift_r  <= 8'h00;
            is_read_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            sen_r       <= 1'b1;
            sclk_r      <= 1'b1;
            sdata_r     <= 1'b0;
            adc_reset_r <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                // DONE also accepts, so back-to-back commands lose no cycle
                S_IDLE, S_DONE: begin
                    if (bus.cmd_valid) begin
                        ph_cnt_r    <= '0;
                        div_r       <= bus.clk_div;
                        is_read_r   <= bus.cmd_read & ~bus.cmd_hwreset;
                        frame_r     <= {bus.cmd_addr[6:0], (bus.cmd_read ? 8'h00 : bus.cmd_wdata)};
                        cmd_ready_r <= 1'b0;
                        if (bus.cmd_hwreset) begin
                            state_r     <= S_RST_PULSE;
                            rst_cnt_r   <= '0;
                            adc_reset_r <= 1'b1;
                        end else begin
                            state_r <= S_SETUP;
                            sen_r   <= 1'b0;
                            sclk_r  <= 1'b1;
                            sdata_r <= bus.cmd_addr[7];
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    if (phase_end_s) begin
                        state_r   <= S_BIT_LO;
                        ph_cnt_r  <= '0;
                        bit_cnt_r <= 4'd0;
                        sclk_r    <= 1'b0;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end
                S_BIT_LO: begin
                    if (phase_end_s) begin
                        // SDOUT is sampled at the last cycle of the low phase, data bits only
                        if (bit_cnt_r[3]) begin
                            rd_shift_r <= {rd_shift_r[6:0], ADC_SDOUT};
                        end
                        ph_cnt_r <= '0;
                        sclk_r   <= 1'b1;
                        if (bit_cnt_r == 4'd15) begin
                            state_r <= S_HOLD;
                        end else begin
                            state_r   <= S_BIT_HI;
                            sdata_r   <= frame_r[14];
                            frame_r   <= {frame_r[13:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end
                S_BIT_HI: begin
                    if (phase_end_s) begin
                        state_r  <= S_BIT_LO;
                        ph_cnt_r <= '0;
                        sclk_r   <= 1'b0;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end
                S_HOLD: begin
                    if (phase_end_s) begin
                        state_r  <= S_GAP;
                        ph_cnt_r <= '0;
                        sen_r    <= 1'b1;
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end
                S_GAP: begin
                    if (phase_end_s) begin
                        state_r     <= S_DONE;
                        ph_cnt_r    <= '0;
                        rsp_valid_r <= 1'b1;
                        cmd_ready_r <= 1'b1;
                        if (is_read_r) begin
                            rsp_rdata_r <= rd_shift_r;
                        end
                    end else begin
                        ph_cnt_r <= ph_cnt_r + PH_ONE;
                    end
                end
                S_RST_PULSE: begin
                    if (rst_cnt_r == RST_PULSE_LAST) begin
                        state_r     <= S_RST_WAIT;
                        rst_cnt_r   <= '0;
                        adc_reset_r <= 1'b0;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RST_ONE;
                    end
                end
                S_RST_WAIT: begin
                    if (rst_cnt_r == RST_WAIT_LAST) begin
                        state_r     <= S_DONE;
                        rst_cnt_r   <= '0;
                        rsp_valid_r <= 1'b1;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RST_ONE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    cmd_ready_r <= 1'b1;
                    sen_r       <= 1'b1;
                    sclk_r      <= 1'b1;
                    adc_reset_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_serial_sequencer.sv
// Self-checking bench for adc_serial_sequencer: directed vector table, hand-written
// corner sequences and random commands against a phase-level reference model.
module tb_adc_serial_sequencer;
    localparam int DW = 8;
    localparam int RC = 4;
    localparam int RW = 16;

    logic clk_usb = 1'b0;
    logic reset_n = 1'b0;
    logic adc_sen, adc_sclk, adc_sdata, adc_reset;
    logic adc_sdout = 1'b0;

    adc_serial_sequencer_if #(.pDIV_WIDTH(DW)) bus ();

    adc_serial_sequencer #(.pDIV_WIDTH(DW), .pRESET_CYCLES(RC), .pRESET_WAIT(RW)) dut (
        .clk_usb   (clk_usb),
        .reset_n   (reset_n),
        .bus       (bus),
        .ADC_SEN   (adc_sen),
        .ADC_SCLK  (adc_sclk),
        .ADC_SDATA (adc_sdata),
        .ADC_RESET (adc_reset),
        .ADC_SDOUT (adc_sdout)
    );

    always #5 clk_usb = ~clk_usb;

    typedef struct {
        logic       hw;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] div;
        logic [7:0] sdout;
        logic [7:0] exp_rdata;
        int         exp_rsp;
    } vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] model_rdata = 8'h00;
    vec_t       tbl[6];

    function automatic vec_t mk(logic hw, logic rd, logic [7:0] addr, logic [7:0] wdata,
                                logic [7:0] div, logic [7:0] sdout, logic [7:0] er, int ersp);
        vec_t v;
        v.hw = hw; v.rd = rd; v.addr = addr; v.wdata = wdata;
        v.div = div; v.sdout = sdout; v.exp_rdata = er; v.exp_rsp = ersp;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic drive_cmd(vec_t v);
        bus.cmd_valid   = 1'b1;
        bus.cmd_hwreset = v.hw;
        bus.cmd_read    = v.rd;
        bus.cmd_addr    = v.addr;
        bus.cmd_wdata   = v.wdata;
        bus.clk_div     = v.div;
    endtask

    task automatic garble(logic valid);
        bus.cmd_valid   = valid;
        bus.cmd_hwreset = 1'($urandom);
        bus.cmd_read    = 1'($urandom);
        bus.cmd_addr    = 8'($urandom);
        bus.cmd_wdata   = 8'($urandom);
        bus.clk_div     = 8'($urandom);
    endtask

    // Present a command from an idle cycle; the next posedge is the accept edge
    task automatic issue_idle(vec_t v, string tag);
        @(posedge clk_usb); #1;
        drive_cmd(v);
        @(negedge clk_usb);
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    // Run one accepted command cycle by cycle against the phase-level model.
    // Called at the negedge of the accept cycle; returns at the negedge of the rsp cycle.
    task automatic run_txn(vec_t c, logic hold, logic has_nxt, vec_t nxt, string tag,
                           output int first_rsp);
        int h, total, p, off;
        int e_sen, e_sclk, e_sd, e_rst, e_rdy, e_rsp, e_rd;
        logic [15:0] frame;
        logic [7:0]  old_rd, exp_rd;
        logic x_sen, x_sclk, x_rst, x_end;
        h = int'(c.div) + 1;
        frame = {c.addr, (c.rd ? 8'h00 : c.wdata)};
        total = c.hw ? (RC + RW + 1) : (34 * h + 1);
        e_sen = 0; e_sclk = 0; e_sd = 0; e_rst = 0; e_rdy = 0; e_rsp = 0; e_rd = 0;
        first_rsp = 0;
        old_rd = model_rdata;
        for (int k = 1; k <= total; k++) begin
            @(posedge clk_usb); #1;
            p = (k - 1) / h;
            off = (k - 1) % h;
            x_end = (k == total);
            if (x_end && has_nxt) drive_cmd(nxt);
            else if (x_end) garble(1'b0);
            else garble(hold);
            // SDOUT is valid only in the last cycle of each data-bit low phase
            if (!c.hw && p >= 17 && p <= 31 && (p % 2) == 1) begin
                adc_sdout = (off == h - 1) ? c.sdout[(31 - p) / 2] : ~c.sdout[(31 - p) / 2];
            end else begin
                adc_sdout = 1'($urandom);
            end
            @(negedge clk_usb);
            if (c.hw) begin
                x_sen = 1'b1; x_sclk = 1'b1; x_rst = (k <= RC) && !x_end;
            end else if (!x_end) begin
                x_sen  = (p <= 32) ? 1'b0 : 1'b1;
                x_sclk = (p >= 1 && p <= 31 && (p % 2) == 1) ? 1'b0 : 1'b1;
                x_rst  = 1'b0;
                if (p <= 31 && adc_sdata !== frame[15 - p / 2]) e_sd++;
            end else begin
                x_sen = 1'b1; x_sclk = 1'b1; x_rst = 1'b0;
            end
            exp_rd = (x_end && c.rd && !c.hw) ? c.sdout : old_rd;
            if (adc_sen !== x_sen) e_sen++;
            if (adc_sclk !== x_sclk) e_sclk++;
            if (adc_reset !== x_rst) e_rst++;
            if (bus.cmd_ready !== x_end || bus.busy !== !x_end) e_rdy++;
            if (bus.rsp_valid !== x_end) e_rsp++;
            if (bus.rsp_rdata !== exp_rd) e_rd++;
            if (bus.rsp_valid === 1'b1 && first_rsp == 0) first_rsp = k;
        end
        if (c.rd && !c.hw) model_rdata = c.sdout;
        check({tag, "_sen"},   32'(e_sen),  32'd0);
        check({tag, "_sclk"},  32'(e_sclk), 32'd0);
        check({tag, "_sdata"}, 32'(e_sd),   32'd0);
        check({tag, "_reset"}, 32'(e_rst),  32'd0);
        check({tag, "_ready"}, 32'(e_rdy),  32'd0);
        check({tag, "_rspv"},  32'(e_rsp),  32'd0);
        check({tag, "_rdata"}, 32'(e_rd),   32'd0);
    endtask

    initial begin
        vec_t v, v2;
        int   rsp_cyc, n_rsp, gap;

        tbl[0] = mk(1'b0, 1'b0, 8'h55, 8'hAA, 8'd0,   8'h00, 8'h00, 35);
        tbl[1] = mk(1'b0, 1'b1, 8'h01, 8'h77, 8'd0,   8'hA5, 8'hA5, 35);
        tbl[2] = mk(1'b0, 1'b1, 8'h02, 8'h00, 8'd3,   8'h3C, 8'h3C, 137);
        tbl[3] = mk(1'b1, 1'b1, 8'h03, 8'h00, 8'd0,   8'hFF, 8'h3C, 21);
        tbl[4] = mk(1'b0, 1'b0, 8'hFF, 8'h00, 8'd255, 8'h00, 8'h3C, 8705);
        tbl[5] = mk(1'b0, 1'b1, 8'h7E, 8'h00, 8'd1,   8'hC3, 8'hC3, 69);

        garble(1'b0);
        repeat (3) @(posedge clk_usb);
        #1 reset_n = 1'b1;
        @(negedge clk_usb);
        check("rst_sen",   32'(adc_sen),       32'd1);
        check("rst_sclk",  32'(adc_sclk),      32'd1);
        check("rst_sdata", 32'(adc_sdata),     32'd0);
        check("rst_reset", 32'(adc_reset),     32'd0);
        check("rst_rspv",  32'(bus.rsp_valid), 32'd0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            issue_idle(tbl[i], $sformatf("vec%0d", i));
            run_txn(tbl[i], 1'b0, 1'b0, tbl[i], $sformatf("vec%0d", i), rsp_cyc);
            check($sformatf("vec%0d_rsp_cycle", i), 32'(rsp_cyc), 32'(tbl[i].exp_rsp));
            check($sformatf("vec%0d_rdata_end", i), 32'(bus.rsp_rdata), 32'(tbl[i].exp_rdata));
        end

        // Reset pulse in the middle of a read discards everything
        v = mk(1'b0, 1'b1, 8'h20, 8'h00, 8'd1, 8'hFF, 8'h00, 0);
        issue_idle(v, "rstmid");
        @(posedge clk_usb); #1;
        garble(1'b0);
        repeat (40) @(posedge clk_usb);
        #1 reset_n = 1'b0;
        @(posedge clk_usb); #1 reset_n = 1'b1;
        @(negedge clk_usb);
        model_rdata = 8'h00;
        check("rstmid_sen",   32'(adc_sen),       32'd1);
        check("rstmid_sclk",  32'(adc_sclk),      32'd1);
        check("rstmid_sdata", 32'(adc_sdata),     32'd0);
        check("rstmid_reset", 32'(adc_reset),     32'd0);
        check("rstmid_rspv",  32'(bus.rsp_valid), 32'd0);
        check("rstmid_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
        n_rsp = 0;
        repeat (80) begin
            @(negedge clk_usb);
            if (bus.rsp_valid === 1'b1) n_rsp++;
        end
        check("rstmid_no_rsp", 32'(n_rsp), 32'd0);

        // Held cmd_valid with changing fields, second command accepted in the rsp cycle
        v  = mk(1'b0, 1'b0, 8'h12, 8'h34, 8'd1, 8'h00, 8'h00, 69);
        v2 = mk(1'b0, 1'b1, 8'h80, 8'h99, 8'd0, 8'h5A, 8'h5A, 35);
        issue_idle(v, "b2b1");
        run_txn(v, 1'b1, 1'b1, v2, "b2b1", rsp_cyc);
        check("b2b1_rsp_cycle", 32'(rsp_cyc), 32'(v.exp_rsp));
        run_txn(v2, 1'b0, 1'b0, v2, "b2b2", rsp_cyc);
        check("b2b2_rsp_cycle", 32'(rsp_cyc), 32'(v2.exp_rsp));
        check("b2b2_rdata_end", 32'(bus.rsp_rdata), 32'(v2.exp_rdata));

        // Random commands, optional held-valid noise and idle gaps
        for (int i = 0; i < 12; i++) begin
            v = mk(($urandom_range(0, 5) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom_range(0, 6)), 8'($urandom), 8'h00, 0);
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk_usb);
            issue_idle(v, $sformatf("rnd%0d", i));
            run_txn(v, 1'($urandom), 1'b0, v, $sformatf("rnd%0d", i), rsp_cyc);
            check($sformatf("rnd%0d_rsp_cycle", i), 32'(rsp_cyc),
                  32'(v.hw ? (RC + RW + 1) : (34 * (int'(v.div) + 1) + 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
